// File: rtl/io_port_bank.sv
`default_nettype none
// ============================================================================
// Module   : io_port_bank
// Brief    : Z80 I/O-space port block with wait states, TX/RX byte FIFOs,
//            scratch and LED registers.
// Revision : 1.0
// ============================================================================
module io_port_bank #(
    parameter logic [7:0] BASE_PORT   = 8'h10,
    parameter int         WAIT_STATES = 2,
    parameter int         TX_DEPTH    = 4,
    parameter int         RX_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [15:0] addr_bus,
    input  logic [7:0]  data_out,
    output wire  [7:0]  data_in,
    input  logic        M1_L,
    input  logic        IORQ_L,
    input  logic        RD_L,
    input  logic        WR_L,
    output wire         WAIT_L,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic [7:0]  led_out
);

    localparam int              c_TXA     = $clog2(TX_DEPTH);
    localparam int              c_RXA     = $clog2(RX_DEPTH);
    localparam logic [c_TXA:0]  c_TX_FULL = (c_TXA + 1)'(TX_DEPTH);
    localparam logic [c_RXA:0]  c_RX_FULL = (c_RXA + 1)'(RX_DEPTH);
    localparam logic [3:0]      c_WAIT    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACT  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_wcnt;
    logic [1:0]       r_off;
    logic             r_rd;
    logic [7:0]       r_rdata;
    logic [7:0]       r_scratch;
    logic [7:0]       r_led;
    logic             r_tx_ovf;

    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [c_TXA-1:0] r_tx_rd;
    logic [c_TXA-1:0] r_tx_wr;
    logic [c_TXA:0]   r_tx_cnt;
    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [c_RXA-1:0] r_rx_rd;
    logic [c_RXA-1:0] r_rx_wr;
    logic [c_RXA:0]   r_rx_cnt;

    logic             w_sel;
    logic             w_act;
    logic             w_tx_empty, w_tx_full, w_tx_pop, w_tx_push_req, w_tx_push;
    logic             w_rx_empty, w_rx_full, w_rx_pop, w_rx_push;
    logic [7:0]       w_status;
    logic [7:0]       w_rval;
    logic             w_drive;
    logic             w_unused;

    assign w_unused = &{1'b0, addr_bus[15:8]};

    // Interrupt-acknowledge cycles also assert IORQ_L; M1_L low excludes them.
    assign w_sel = !IORQ_L && M1_L && ((!RD_L) ^ (!WR_L))
                   && (addr_bus[7:2] == BASE_PORT[7:2]);
    assign w_act = (r_state == S_ACT);

    assign w_tx_empty    = (r_tx_cnt == '0);
    assign w_tx_full     = (r_tx_cnt == c_TX_FULL);
    assign w_tx_pop      = tx_valid && tx_ready;
    assign w_tx_push_req = w_act && !r_rd && (r_off == 2'd0);
    assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);

    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == c_RX_FULL);
    assign w_rx_push  = rx_valid && rx_ready;
    assign w_rx_pop   = w_act && r_rd && (r_off == 2'd0) && !w_rx_empty;

    assign tx_valid = !w_tx_empty;
    assign tx_data  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd];
    assign rx_ready = !w_rx_full;
    assign led_out  = r_led;

    assign w_status = {2'b00, r_tx_ovf, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, 1'b0};

    always_comb begin
        w_rval = 8'h00;
        case (r_off)
            2'd0:    w_rval = w_rx_empty ? 8'hFF : r_rx_mem[r_rx_rd];
            2'd1:    w_rval = w_status;
            2'd2:    w_rval = r_scratch;
            default: w_rval = r_led;
        endcase
    end

    // During ACT the register isn't loaded yet, so the live mux drives the bus.
    assign w_drive = !RD_L && r_rd && ((r_state == S_ACT) || (r_state == S_HOLD));
    assign data_in = w_drive ? ((r_state == S_ACT) ? w_rval : r_rdata) : 8'hzz;
    assign WAIT_L  = (r_state == S_WAIT) ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_sel) w_state_nxt = (c_WAIT == 4'd0) ? S_ACT : S_WAIT;
            S_WAIT: begin
                if (IORQ_L) begin
                    w_state_nxt = S_IDLE;
                end else if (r_wcnt <= 4'd1) begin
                    w_state_nxt = S_ACT;
                end
            end
            S_ACT:  w_state_nxt = S_HOLD;
            S_HOLD: if (IORQ_L) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            r_wcnt    <= 4'd0;
            r_off     <= 2'd0;
            r_rd      <= 1'b0;
            r_rdata   <= 8'h00;
            r_scratch <= 8'h00;
            r_led     <= 8'h00;
            r_tx_ovf  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_sel) begin
                r_wcnt <= c_WAIT;
                r_off  <= addr_bus[1:0];
                r_rd   <= !RD_L;
            end else if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            if (w_act) begin
                if (r_rd) begin
                    r_rdata <= w_rval;
                end else begin
                    case (r_off)
                        2'd2:    r_scratch <= data_out;
                        2'd3:    r_led     <= data_out;
                        default: ;
                    endcase
                end
            end
            if (w_tx_push_req && !w_tx_push) begin
                r_tx_ovf <= 1'b1;
            end else if (w_act && !r_rd && (r_off == 2'd1) && data_out[5]) begin
                r_tx_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            r_tx_rd  <= '0;
            r_tx_wr  <= '0;
            r_tx_cnt <= '0;
            r_rx_rd  <= '0;
            r_rx_wr  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + c_TXA'(1);
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_TXA'(1);
            if (w_tx_push && !w_tx_pop) begin
                r_tx_cnt <= r_tx_cnt + (c_TXA + 1)'(1);
            end else if (!w_tx_push && w_tx_pop) begin
                r_tx_cnt <= r_tx_cnt - (c_TXA + 1)'(1);
            end
            if (w_rx_push) r_rx_wr <= r_rx_wr + c_RXA'(1);
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_RXA'(1);
            if (w_rx_push && !w_rx_pop) begin
                r_rx_cnt <= r_rx_cnt + (c_RXA + 1)'(1);
            end else if (!w_rx_push && w_rx_pop) begin
                r_rx_cnt <= r_rx_cnt - (c_RXA + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= data_out;
        if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_io_port_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_port_bank
// Brief    : Scoreboard bench for io_port_bank: bus-cycle and TX-stream monitors.
// Revision : 1.0
// ============================================================================
module tb_io_port_bank;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic [15:0] addr_bus = 16'h0000;
    logic [7:0]  data_out = 8'h00;
    logic        M1_L = 1'b1;
    logic        IORQ_L = 1'b1;
    logic        RD_L = 1'b1;
    logic        WR_L = 1'b1;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    tri1  [7:0]  data_in;
    tri1         WAIT_L;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        rx_ready;
    logic [7:0]  led_out;

    io_port_bank #(
        .BASE_PORT   (8'h10),
        .WAIT_STATES (2),
        .TX_DEPTH    (4),
        .RX_DEPTH    (4)
    ) dut (
        .clk      (clk),
        .rst_L    (rst_L),
        .addr_bus (addr_bus),
        .data_out (data_out),
        .data_in  (data_in),
        .M1_L     (M1_L),
        .IORQ_L   (IORQ_L),
        .RD_L     (RD_L),
        .WR_L     (WR_L),
        .WAIT_L   (WAIT_L),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .led_out  (led_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rd;
        logic [7:0] data;
        int         waits;
        int         id;
    } exp_t;

    exp_t       bus_q[$];
    logic [7:0] tx_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_id  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", nm);
    endtask

    task automatic exp_bus(input bit rd, input logic [7:0] d, input int w);
        exp_t e;
        e.rd = rd; e.data = d; e.waits = w; e.id = n_id;
        n_id++;
        bus_q.push_back(e);
    endtask

    // One Z80 IN/OUT cycle; the bus is held until WAIT_L is released.
    task automatic io_cycle(input bit rd, input logic [7:0] port, input logic [7:0] wd,
                            input bit intack);
        int cnt;
        @(posedge clk); #1;
        addr_bus = {8'hC3, port};
        data_out = wd;
        M1_L     = !intack;
        IORQ_L   = 1'b0;
        RD_L     = !rd;
        WR_L     = rd;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while ((cnt < 2 || WAIT_L === 1'b0) && cnt < 40);
        if (cnt >= 40) fail_now("bus_wait_timeout");
        @(posedge clk); #1;
        IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; M1_L = 1'b1;
    endtask

    task automatic push_rx(input logic [7:0] b);
        int cnt;
        bit ok;
        cnt = 0;
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        do begin
            @(negedge clk);
            ok = rx_ready;
            cnt++;
            @(posedge clk);
        end while (!ok && cnt < 40);
        #1 rx_valid = 1'b0;
        if (!ok) fail_now("rx_push_timeout");
    endtask

    // Monitor: closes each bus cycle on IORQ_L rising and drains the TX stream.
    initial begin : g_monitor
        int         waits;
        logic [7:0] cap;
        bit         prev;
        exp_t       e;
        logic [7:0] t;
        waits = 0; cap = 8'hFF; prev = 1'b1;
        forever begin
            @(negedge clk);
            if (IORQ_L == 1'b0) begin
                if (WAIT_L === 1'b0) waits++;
                if (RD_L == 1'b0) cap = data_in;
            end else if (!prev) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", 1, 0);
                end else begin
                    e = bus_q.pop_front();
                    chk($sformatf("bus%0d_waits", e.id), waits, e.waits);
                    if (e.rd) chk($sformatf("bus%0d_data", e.id), cap, e.data);
                end
                waits = 0;
                cap   = 8'hFF;
            end
            prev = IORQ_L;
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    chk("tx_unexpected", tx_data, 8'h00);
                    if (tx_data == 8'h00) chk("tx_unexpected_pop", 1, 0);
                end else begin
                    t = tx_q.pop_front();
                    chk("tx_data", tx_data, t);
                end
            end
        end
    end

    initial begin : g_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : g_stim
        int cnt;
        repeat (3) @(posedge clk);
        #1 rst_L = 1'b1;
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_led", led_out, 8'h00);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_wait_z", WAIT_L, 1);
        chk("rst_data_z", data_in, 8'hFF);

        // LED and scratch write/read-back
        exp_bus(0, 8'h00, 2); io_cycle(0, 8'h13, 8'hA5, 0);
        @(negedge clk); chk("led_a5", led_out, 8'hA5);
        exp_bus(1, 8'hA5, 2); io_cycle(1, 8'h13, 8'h00, 0);
        exp_bus(0, 8'h00, 2); io_cycle(0, 8'h12, 8'h3C, 0);
        exp_bus(1, 8'h3C, 2); io_cycle(1, 8'h12, 8'h00, 0);

        // Ports just outside the window must not respond
        exp_bus(0, 8'h00, 0); io_cycle(0, 8'h14, 8'hEE, 0);
        exp_bus(1, 8'hFF, 0); io_cycle(1, 8'h0F, 8'h00, 0);
        @(negedge clk); chk("led_unchanged", led_out, 8'hA5);

        // TX overflow: four accepted, fifth dropped
        for (int i = 0; i < 5; i++) begin
            exp_bus(0, 8'h00, 2);
            if (i < 4) tx_q.push_back(8'((i + 1) * 8'h11));
            io_cycle(0, 8'h10, 8'((i + 1) * 8'h11), 0);
        end
        @(negedge clk);
        chk("tx_valid_full", tx_valid, 1);
        chk("tx_head", tx_data, 8'h11);
        exp_bus(1, 8'h32, 2); io_cycle(1, 8'h11, 8'h00, 0);
        exp_bus(0, 8'h00, 2); io_cycle(0, 8'h11, 8'h20, 0);
        exp_bus(1, 8'h12, 2); io_cycle(1, 8'h11, 8'h00, 0);
        @(posedge clk); #1 tx_ready = 1'b1;
        cnt = 0;
        while (tx_valid && cnt < 40) begin @(negedge clk); cnt++; end
        if (cnt >= 40) fail_now("tx_drain_timeout");
        exp_bus(1, 8'h0A, 2); io_cycle(1, 8'h11, 8'h00, 0);

        // RX: two bytes then an empty read
        push_rx(8'h01);
        push_rx(8'h02);
        exp_bus(1, 8'h01, 2); io_cycle(1, 8'h10, 8'h00, 0);
        exp_bus(1, 8'h02, 2); io_cycle(1, 8'h10, 8'h00, 0);
        exp_bus(1, 8'hFF, 2); io_cycle(1, 8'h10, 8'h00, 0);
        exp_bus(1, 8'h0A, 2); io_cycle(1, 8'h11, 8'h00, 0);

        // Interrupt acknowledge at the DATA port: no wait, no pop, bus floats
        push_rx(8'h77);
        exp_bus(1, 8'hFF, 0); io_cycle(1, 8'h10, 8'h00, 1);
        exp_bus(1, 8'h77, 2); io_cycle(1, 8'h10, 8'h00, 0);

        // RX full, then CPU pop while the producer is offering
        for (int i = 0; i < 4; i++) push_rx(8'(8'hA1 + i));
        @(negedge clk); chk("rx_ready_full", rx_ready, 0);
        exp_bus(1, 8'h0C, 2); io_cycle(1, 8'h11, 8'h00, 0);
        exp_bus(1, 8'hA1, 2);
        fork
            push_rx(8'hA5);
            io_cycle(1, 8'h10, 8'h00, 0);
        join
        @(negedge clk); chk("rx_ready_refull", rx_ready, 0);
        for (int i = 0; i < 4; i++) begin
            exp_bus(1, 8'(8'hA2 + i), 2); io_cycle(1, 8'h10, 8'h00, 0);
        end
        @(negedge clk); chk("rx_ready_empty", rx_ready, 1);

        // Aborted OUT to LED: IORQ_L rises during WAIT
        exp_bus(0, 8'h00, 1);
        @(posedge clk); #1;
        addr_bus = 16'h0013; data_out = 8'h5A; IORQ_L = 1'b0; WR_L = 1'b0;
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1 IORQ_L = 1'b1; WR_L = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_led", led_out, 8'hA5);

        // Reset asserted during WAIT of an OUT to LED
        exp_bus(0, 8'h00, 2);
        @(posedge clk); #1;
        addr_bus = 16'h0013; data_out = 8'h66; IORQ_L = 1'b0; WR_L = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_mid_wait_low", WAIT_L, 0);
        @(posedge clk); #1 rst_L = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_wait_z", WAIT_L, 1);
        chk("rst_mid_led", led_out, 8'h00);
        @(posedge clk); #1 rst_L = 1'b1; IORQ_L = 1'b1; WR_L = 1'b1;
        exp_bus(1, 8'h0A, 2); io_cycle(1, 8'h11, 8'h00, 0);
        exp_bus(1, 8'h00, 2); io_cycle(1, 8'h13, 8'h00, 0);
        @(negedge clk);
        chk("post_rst_led", led_out, 8'h00);
        chk("post_rst_tx_valid", tx_valid, 0);

        cnt = 0;
        while (bus_q.size() != 0 && cnt < 20) begin @(negedge clk); cnt++; end
        chk("bus_q_left", bus_q.size(), 0);
        chk("tx_q_left", tx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
